fetch_seq: RTL and testbench

- Instruction-fetch sequencer that owns the architectural PC register and schedules its updates: sequential PC+4 or redirect targets from the next-PC logic (branch taken, j, jal).
- Drives a single-outstanding-request instruction memory port with variable latency.
- Delivers fetched instructions to decode through a valid/ready handshake.
- Kills wrong-path fetches on redirect.

---
 rtl/fetch_seq.sv | 189 ++++++++++++++++++
 tb/tb_fetch_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer owning the architectural PC.
// Issues one outstanding imem request at a time, delivers the
// returned word to decode over a valid/ready handshake, and kills
// wrong-path fetches on redirect.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   redir_valid/redir_pc  PC redirect from next-PC logic
//   imem_req/imem_addr    fetch request and address (= pc)
//   imem_gnt              memory accepts the request
//   imem_rvalid/rdata     returned instruction word
//   if_valid/instr/pc     instruction handed to decode
//   if_ready              decode accepts the instruction
//   pc                    current fetch PC register
//
// Build option: define FETCH_DELAY_SLOT_EN for MIPS delay-slot
// semantics (redirects are deferred until the in-flight or held
// fetch has been handed to decode; nothing is killed).

module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] req_pc;
    logic [31:0] redir_tgt;

`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_pc;
`else
    logic        kill;
`endif

    // Targets are always word aligned.
    assign redir_tgt = {redir_pc[31:2], 2'b00};

    // The address is the PC itself, so it stays stable while
    // the request waits for a grant.
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
            req_pc   <= 32'h0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
`else
            kill     <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (redir_valid)
                        pc <= redir_tgt;
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end

                S_REQ: begin
`ifdef FETCH_DELAY_SLOT_EN
                    if (redir_valid) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= redir_tgt;
                    end
                    if (imem_gnt) begin
                        req_pc   <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end
`else
                    if (redir_valid) begin
                        pc <= redir_tgt;
                        // Granted fetch is wrong-path now.
                        if (imem_gnt) begin
                            req_pc   <= pc;
                            kill     <= 1'b1;
                            state    <= S_WAIT;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_gnt) begin
                        req_pc   <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end
`endif
                end

                S_WAIT: begin
`ifdef FETCH_DELAY_SLOT_EN
                    if (redir_valid) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= redir_tgt;
                    end
                    if (imem_rvalid) begin
                        if_instr <= imem_rdata;
                        if_pc    <= req_pc;
                        if_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
`else
                    if (imem_rvalid) begin
                        if (redir_valid || kill) begin
                            if (redir_valid)
                                pc <= redir_tgt;
                            kill     <= 1'b0;
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= req_pc;
                            if_valid <= 1'b1;
                            state    <= S_HOLD;
                        end
                    end else if (redir_valid) begin
                        pc   <= redir_tgt;
                        kill <= 1'b1;
                    end
`endif
                end

                S_HOLD: begin
`ifdef FETCH_DELAY_SLOT_EN
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                        // A fresh redirect beats a pending one.
                        if (redir_valid) begin
                            pc         <= redir_tgt;
                            pend_valid <= 1'b0;
                        end else if (pend_valid) begin
                            pc         <= pend_pc;
                            pend_valid <= 1'b0;
                        end
                    end else if (redir_valid) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= redir_tgt;
                    end
`else
                    // Redirect drops the held word even if
                    // decode is accepting it this cycle.
                    if (redir_valid) begin
                        if_valid <= 1'b0;
                        pc       <= redir_tgt;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end else if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed self-checking bench for fetch_seq.
// Inputs change 1 time unit after the rising edge; outputs are checked there.

module tb_fetch_seq;

    logic        clk;
    logic        rst;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_seq #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full fetch with 1-cycle grant and data, if_ready=1.
    // Entered in REQ, leaves in REQ for the next address.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        chk("req_hi", {31'h0, imem_req}, 32'h1);
        chk("addr", imem_addr, a);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("wait_pc", pc, a + 32'd4);
        chk("wait_req", {31'h0, imem_req}, 32'h0);
        chk("wait_v", {31'h0, if_valid}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
        chk("hold_v", {31'h0, if_valid}, 32'h1);
        chk("hold_instr", if_instr, d);
        chk("hold_pc", if_pc, a);
        tick();
        chk("after_v", {31'h0, if_valid}, 32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if_ready    = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state (IDLE)
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_v", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_ifpc", if_pc, 32'h0);
        tick();

        // Sequential fetch, 3 cycles per instruction
        fetch(32'h0000_3000, 32'hAAAA_0000);
        fetch(32'h0000_3004, 32'hAAAA_0004);
        fetch(32'h0000_3008, 32'hAAAA_0008);

        // Decode stalls 5 cycles in HOLD
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        if_ready    = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("stall_v", {31'h0, if_valid}, 32'h1);
            chk("stall_instr", if_instr, 32'h1234_5678);
            chk("stall_pc", if_pc, 32'h0000_300C);
            chk("stall_req", {31'h0, imem_req}, 32'h0);
            tick();
        end
        if_ready = 1'b1;
        tick();
        chk("resume_req", {31'h0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr, 32'h0000_3010);

`ifdef FETCH_DELAY_SLOT_EN
        // Redirect in WAIT: 3010 is the delay slot
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3200;
        tick();
        redir_valid = 1'b0;
        chk("ds_pc", pc, 32'h0000_3014);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5107_5107;
        tick();
        imem_rvalid = 1'b0;
        chk("ds_v", {31'h0, if_valid}, 32'h1);
        chk("ds_instr", if_instr, 32'h5107_5107);
        chk("ds_ifpc", if_pc, 32'h0000_3010);
        tick();
        chk("ds_after_v", {31'h0, if_valid}, 32'h0);
        chk("ds_addr", imem_addr, 32'h0000_3200);
        chk("ds_req", {31'h0, imem_req}, 32'h1);
`else
        // Redirect while waiting for 3010's data
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3040;
        tick();
        redir_valid = 1'b0;
        chk("rw_pc", pc, 32'h0000_3040);
        chk("rw_req", {31'h0, imem_req}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0010;
        tick();
        imem_rvalid = 1'b0;
        chk("rw_v", {31'h0, if_valid}, 32'h0);
        chk("rw_req2", {31'h0, imem_req}, 32'h1);
        chk("rw_addr", imem_addr, 32'h0000_3040);

        // Redirect together with grant, unaligned target
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3103;
        imem_gnt    = 1'b1;
        tick();
        redir_valid = 1'b0;
        imem_gnt    = 1'b0;
        chk("rg_pc", pc, 32'h0000_3100);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0040;
        tick();
        imem_rvalid = 1'b0;
        chk("rg_v", {31'h0, if_valid}, 32'h0);
        chk("rg_addr", imem_addr, 32'h0000_3100);
        chk("rg_req", {31'h0, imem_req}, 32'h1);

        // Back-to-back redirects in REQ: last one wins;
        // rvalid outside WAIT is ignored
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3300;
        imem_rvalid = 1'b1;
        tick();
        redir_pc = 32'h0000_3400;
        tick();
        redir_valid = 1'b0;
        imem_rvalid = 1'b0;
        chk("rr_addr", imem_addr, 32'h0000_3400);
        chk("rr_v", {31'h0, if_valid}, 32'h0);

        // Redirect in HOLD drops the word despite if_ready
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_3400;
        tick();
        imem_rvalid = 1'b0;
        chk("rh_v0", {31'h0, if_valid}, 32'h1);
        redir_valid = 1'b1;
        redir_pc    = 32'h0000_3500;
        tick();
        redir_valid = 1'b0;
        chk("rh_v1", {31'h0, if_valid}, 32'h0);
        chk("rh_addr", imem_addr, 32'h0000_3500);

        // Wrap at the top of the address space
        redir_valid = 1'b1;
        redir_pc    = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("wr_pc", pc, 32'h0000_0000);

        // Reset while waiting; late data ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw2_pc", pc, 32'h0000_3000);
        chk("rw2_v", {31'h0, if_valid}, 32'h0);
        chk("rw2_req", {31'h0, imem_req}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_FFFC;
        tick();
        imem_rvalid = 1'b0;
        chk("late_v", {31'h0, if_valid}, 32'h0);
        chk("late_addr", imem_addr, 32'h0000_3000);
        chk("late_req", {31'h0, imem_req}, 32'h1);
        fetch(32'h0000_3000, 32'hCAFE_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
